// File: rtl/core_host_driver.sv
// core_host_driver: streams x/w words into the core SRAMs, waits for the
// convolution, then reads the psum bank back out over a valid/ready port.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, busy, done     job start, job in progress, one-cycle job-end pulse
//   err                   watchdog error, sticky until the next start
//   in_valid/in_ready     input word stream (x words, then w words)
//   in_data               input word (bw*row bits)
//   out_valid/out_ready   psum output stream
//   out_data, out_addr    psum word and its index
//   core_*                SRAM / core control and data
//
// Optional feature: define HOST_TIMEOUT_EN to enable the WAIT_CONV
// watchdog (TIMEOUT_CYCLES) and the ERROR state.
module core_host_driver #(
  parameter int bw             = 4,
  parameter int row            = 8,
  parameter int col            = 8,
  parameter int psum_bw        = 16,
  parameter int X_WORDS        = 144,
  parameter int W_WORDS        = 72,
  parameter int P_WORDS        = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bw*row-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [psum_bw*col-1:0] out_data,
  output logic [3:0]             out_addr,
  output logic [7:0]             core_addr,
  output logic                   core_ibank_sel,
  output logic                   core_wen,
  output logic                   core_cen,
  output logic [bw*row-1:0]      core_data_in,
  input  logic [psum_bw*col-1:0] core_data_out,
  output logic                   core_mem_load_complete,
  input  logic                   core_convolution_complete
);

  localparam int MXW = (X_WORDS > W_WORDS) ? X_WORDS : W_WORDS;
  localparam int MX  = (MXW > P_WORDS) ? MXW : P_WORDS;
  localparam int CW  = $clog2(MX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_W,
    S_WAIT_CONV,
    S_RD_ISSUE,
    S_RD_CAPT,
    S_RD_HOLD,
    S_ERROR
  } state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic                     r_done;
  logic                     r_mlc;
  logic [psum_bw*col-1:0]   r_out_data;
  logic [3:0]               r_out_addr;
  logic                     w_xfer;

  assign in_ready  = (r_state == S_LOAD_X) || (r_state == S_LOAD_W);
  assign w_xfer    = in_ready && in_valid;
  assign busy      = !((r_state == S_IDLE) || (r_state == S_ERROR));
  assign out_valid = (r_state == S_RD_HOLD);
  assign done      = r_done;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign core_mem_load_complete = r_mlc;

  // Writes are driven in the same cycle the input handshake happens.
  always_comb begin
    core_cen       = 1'b1;
    core_wen       = 1'b1;
    core_ibank_sel = 1'b0;
    core_addr      = '0;
    core_data_in   = '0;
    if (w_xfer) begin
      core_cen       = 1'b0;
      core_wen       = 1'b0;
      core_ibank_sel = (r_state == S_LOAD_W);
      core_addr      = 8'(r_cnt);
      core_data_in   = in_data;
    end else if (r_state == S_RD_ISSUE) begin
      core_cen  = 1'b0;
      core_addr = {4'b0, r_cnt[3:0]};
    end
  end

`ifdef HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tcnt;
  logic          r_err;
  logic          w_timeout;

  assign w_timeout = (r_state == S_WAIT_CONV) &&
                     !core_convolution_complete &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign err = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_WAIT_CONV) r_tcnt <= r_tcnt + TW'(1);
      else                        r_tcnt <= '0;
      if (w_timeout)                           r_err <= 1'b1;
      else if (start && r_state == S_ERROR)    r_err <= 1'b0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_mlc      <= 1'b0;
      r_out_data <= '0;
      r_out_addr <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD_X;
            r_cnt   <= '0;
          end
        end
        S_LOAD_X: begin
          if (in_valid) begin
            if (r_cnt == CW'(X_WORDS - 1)) begin
              r_state <= S_LOAD_W;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_LOAD_W: begin
          if (in_valid) begin
            if (r_cnt == CW'(W_WORDS - 1)) begin
              r_state <= S_WAIT_CONV;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_WAIT_CONV: begin
          // Rises one cycle after entry, drops once completion is seen.
          r_mlc <= !core_convolution_complete;
          if (core_convolution_complete) begin
            r_state <= S_RD_ISSUE;
            r_cnt   <= '0;
          end
`ifdef HOST_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= S_ERROR;
            r_mlc   <= 1'b0;
          end
`endif
        end
        S_RD_ISSUE: r_state <= S_RD_CAPT;
        S_RD_CAPT: begin
          // SRAM has one cycle of read latency after the issue cycle.
          r_out_data <= core_data_out;
          r_out_addr <= r_cnt[3:0];
          r_state    <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (out_ready) begin
            if (r_cnt == CW'(P_WORDS - 1)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_state <= S_RD_ISSUE;
            end
          end
        end
        S_ERROR: begin
          if (start) begin
            r_state <= S_LOAD_X;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_host_driver.sv
// tb_core_host_driver: scoreboard bench for core_host_driver.
// Loads, waits, reads back; checks writes, handshakes, reset, watchdog.
module tb_core_host_driver;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int XW  = 144;
  localparam int WW  = 72;
  localparam int PW  = 16;
  localparam int TMO = 100;
  localparam int DW  = BW * ROW;
  localparam int OW  = PBW * COL;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [3:0]    out_addr;
  logic [7:0]    core_addr;
  logic          core_ibank_sel;
  logic          core_wen;
  logic          core_cen;
  logic [DW-1:0] core_data_in;
  logic [OW-1:0] core_data_out;
  logic          core_mem_load_complete;
  logic          core_convolution_complete;

  core_host_driver #(
    .bw(BW), .row(ROW), .col(COL), .psum_bw(PBW),
    .X_WORDS(XW), .W_WORDS(WW), .P_WORDS(PW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .err(err),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_addr(out_addr),
    .core_addr(core_addr),
    .core_ibank_sel(core_ibank_sel),
    .core_wen(core_wen),
    .core_cen(core_cen),
    .core_data_in(core_data_in),
    .core_data_out(core_data_out),
    .core_mem_load_complete(core_mem_load_complete),
    .core_convolution_complete(core_convolution_complete)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW+8:0] wq[$];
  logic [OW+3:0] rq[$];
  logic [OW-1:0] psum_mem [PW];

  // psum bank model: one cycle read latency
  always @(posedge clk)
    if (!core_cen && core_wen)
      core_data_out <= psum_mem[core_addr[3:0]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    core_convolution_complete = 1'b0;
    repeat (2) tick;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err, in_ready, out_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=00000",
               {busy, done, err, in_ready, out_valid});
    end
    n_checks++;
    if ({core_cen, core_wen, core_ibank_sel, core_mem_load_complete}
        !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_core got=%b exp=1100",
               {core_cen, core_wen, core_ibank_sel, core_mem_load_complete});
    end
    n_checks++;
    if (out_data !== '0 || out_addr !== 4'd0 ||
        core_addr !== 8'd0 || core_data_in !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0",
               out_data, out_addr, core_addr, core_data_in);
    end
    tick;
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_load(input int nx, input int nw, input bit gap);
    int total;
    int sent;
    int cyc;
    bit pres;
    logic [DW+8:0] e;
    total = nx + nw;
    sent = 0;
    cyc = 0;
    pres = 1'b0;
    wq.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
    while (sent < total && cyc < 2000) begin
      if (gap && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        if (!pres) begin
          in_data = $urandom;
          if (sent < nx) e = {1'b0, 8'(sent), in_data};
          else           e = {1'b1, 8'(sent - nx), in_data};
          wq.push_back(e);
          pres = 1'b1;
        end
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        e = wq.pop_front();
        n_checks++;
        if ({core_cen, core_wen, core_ibank_sel, core_addr, core_data_in}
            !== {2'b00, e}) begin
          n_fail++;
          $display("FAIL load_write got=%h exp=%h",
                   {core_cen, core_wen, core_ibank_sel, core_addr,
                    core_data_in}, {2'b00, e});
        end
        sent++;
        pres = 1'b0;
      end else begin
        n_checks++;
        if ({core_cen, core_wen} !== 2'b11) begin
          n_fail++;
          $display("FAIL gap_write got=%b exp=11", {core_cen, core_wen});
        end
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (sent != total) begin
      n_fail++;
      $display("FAIL load_count got=%0d exp=%0d", sent, total);
    end
  endtask

  task automatic test_reset_mid_load;
    do_load(10, 0, 1'b0);
    reset = 1'b1;
    start = 1'b1;
    tick;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, core_cen, core_wen, in_ready} !== 4'b0110) begin
      n_fail++;
      $display("FAIL midload_reset got=%b exp=0110",
               {busy, core_cen, core_wen, in_ready});
    end
    tick;
  endtask

  task automatic test_wait_conv(input int hold);
    int bad;
    bad = 0;
    for (int i = 0; i < PW; i++)
      psum_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    n_checks++;
    if ({busy, core_mem_load_complete} !== 2'b10) begin
      n_fail++;
      $display("FAIL wait_entry got=%b exp=10",
               {busy, core_mem_load_complete});
    end
    for (int i = 1; i < hold; i++) begin
      tick;
      @(negedge clk);
      n_checks++;
      if (core_mem_load_complete !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        bad++;
        $display("FAIL mlc_hold got=%b exp=11",
                 {core_mem_load_complete, busy});
      end
    end
    tick;
    core_convolution_complete = 1'b1;
    rq.delete();
    for (int i = 0; i < PW; i++)
      rq.push_back({4'(i), psum_mem[i]});
    @(negedge clk);
    n_checks++;
    if (core_mem_load_complete !== 1'b1) begin
      n_fail++;
      $display("FAIL mlc_at_complete got=%b exp=1", core_mem_load_complete);
    end
    tick;
    core_convolution_complete = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_mem_load_complete, core_cen, core_wen, core_addr}
        !== {3'b001, 8'd0}) begin
      n_fail++;
      $display("FAIL first_read got=%b exp=%b",
               {core_mem_load_complete, core_cen, core_wen, core_addr},
               {3'b001, 8'd0});
    end
  endtask

  task automatic test_readback(input int sidx, input int nst);
    int got;
    int st;
    int dones;
    int cyc;
    int last;
    int extra;
    logic [OW+3:0] e;
    got = 0;
    st = 0;
    dones = 0;
    cyc = 0;
    last = -10;
    extra = 0;
    while (extra < 3 && cyc < 500) begin
      tick;
      cyc++;
      if (got == PW) extra++;
      out_ready = out_valid && !(got == sidx && st < nst);
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (out_valid && !out_ready) begin
        st++;
        n_checks++;
        if (rq.size() == 0 || {out_addr, out_data} !== rq[0]) begin
          n_fail++;
          $display("FAIL stall_hold got=%h/%h", out_addr, out_data);
        end
      end else if (out_valid) begin
        if (rq.size() > 0) e = rq.pop_front();
        else               e = 'x;
        n_checks++;
        if ({out_addr, out_data} !== e) begin
          n_fail++;
          $display("FAIL psum_word got=%h exp=%h", {out_addr, out_data}, e);
        end
        n_checks++;
        if (cyc - last < 3) begin
          n_fail++;
          $display("FAIL throughput gap got=%0d exp>=3", cyc - last);
        end
        last = cyc;
        got++;
      end
    end
    out_ready = 1'b0;
    n_checks++;
    if (got != PW) begin
      n_fail++;
      $display("FAIL psum_count got=%0d exp=%0d", got, PW);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL done_pulses got=%0d exp=1", dones);
    end
    n_checks++;
    if (st != nst) begin
      n_fail++;
      $display("FAIL stall_cycles got=%0d exp=%0d", st, nst);
    end
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after got=%b exp=00", {busy, out_valid});
    end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    do_load(XW, WW, 1'b0);
`ifdef HOST_TIMEOUT_EN
    @(negedge clk);
    while (busy === 1'b1 && n < 300) begin
      n++;
      tick;
      @(negedge clk);
    end
    n_checks++;
    if (n != TMO) begin
      n_fail++;
      $display("FAIL timeout_cycles got=%0d exp=%0d", n, TMO);
    end
    n_checks++;
    if ({err, busy, core_mem_load_complete} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_flags got=%b exp=100",
               {err, busy, core_mem_load_complete});
    end
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({err, busy, in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL err_clear got=%b exp=011", {err, busy, in_ready});
    end
`else
    repeat (200) begin
      tick;
      n++;
    end
    @(negedge clk);
    n_checks++;
    if ({err, busy, core_mem_load_complete} !== 3'b011) begin
      n_fail++;
      $display("FAIL wait_forever got=%b exp=011 after %0d",
               {err, busy, core_mem_load_complete}, n);
    end
`endif
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_reset_mid_load;
    do_load(XW, WW, 1'b1);
    test_wait_conv(50);
    test_readback(3, 5);
    do_load(XW, WW, 1'b0);
    test_wait_conv(3);
    test_readback(99, 0);
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_host_driver.md
CORE_HOST_DRIVER -- requirements
Module: core_host_driver

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: bw, 4, activation/weight bits; row, 8, input channels; col, 8, output channels; psum_bw, 16, psum bits; X_WORDS, 144, x_bank words loaded; W_WORDS, 72, w_bank words loaded; P_WORDS, 16, psum words read back; TIMEOUT_CYCLES, 65535, watchdog limit.
REQ-002 Ports (name direction width meaning) SHALL be: clk in 1 clock; reset in 1 synchronous active-high reset; start in 1 begin one job; busy out 1 job in progress; done out 1 one-cycle job-end pulse; err out 1 watchdog error, sticky until next start.
REQ-003 Input stream SHALL be: in_valid in 1; in_ready out 1; in_data in bw*row, x words first, then w words.
REQ-004 Output stream SHALL be: out_valid out 1; out_ready in 1; out_data out psum_bw*col psum word; out_addr out 4 psum index.
REQ-005 Core side SHALL be: core_addr out 8 ADDR; core_ibank_sel out 1 (0 x_bank, 1 w_bank); core_wen out 1 (0 write); core_cen out 1 (0 enable); core_data_in out bw*row; core_data_out in psum_bw*col; core_mem_load_complete out 1; core_convolution_complete in 1.

Function
REQ-006 States SHALL be IDLE, LOAD_X, LOAD_W, WAIT_CONV, RD_ISSUE, RD_CAPT, RD_HOLD, ERROR.
REQ-007 IDLE: start=1 -> LOAD_X, word counter cleared; start ignored in all other states.
REQ-008 LOAD_X: in_ready=1; each in_valid&in_ready cycle drives core_cen=0, core_wen=0, core_ibank_sel=0, core_addr=counter, core_data_in=in_data in that same cycle; counter increments; after word X_WORDS-1 -> LOAD_W, counter cleared.
REQ-009 LOAD_W: identical with core_ibank_sel=1; after word W_WORDS-1 -> WAIT_CONV.
REQ-010 Cycles without a transfer SHALL drive core_cen=1, core_wen=1; in_ready=0 outside LOAD_X/LOAD_W.
REQ-011 core_mem_load_complete SHALL be registered, rising the cycle after entering WAIT_CONV, held high until core_convolution_complete is sampled 1, then low.
REQ-012 WAIT_CONV: core_convolution_complete=1 -> RD_ISSUE, read index cleared.
REQ-013 RD_ISSUE: core_cen=0, core_wen=1, core_addr={4'b0,index} for one cycle -> RD_CAPT.
REQ-014 RD_CAPT: core_data_out (1-cycle sram latency) registered into out_data, index into out_addr -> RD_HOLD.
REQ-015 RD_HOLD: out_valid=1, out_data/out_addr stable; out_ready=1 -> index+1 and RD_ISSUE, or after index P_WORDS-1 -> IDLE with done=1 for one cycle.
REQ-016 Throughput SHALL be at most one psum word per 3 cycles; out_valid low outside RD_HOLD.
REQ-017 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-018 Counters SHALL be wide enough for max(X_WORDS,W_WORDS,P_WORDS) with no wrap within a job.

Reset
REQ-019 reset=1 at any clock edge, including mid-load or mid-readback, SHALL force IDLE, counters 0, busy=0, done=0, err=0, in_ready=0, out_valid=0, out_data=0, out_addr=0, core_cen=1, core_wen=1, core_ibank_sel=0, core_addr=0, core_data_in=0, core_mem_load_complete=0; reset dominates start.

Configuration
REQ-020 Macro HOST_TIMEOUT_EN defined: a WAIT_CONV cycle counter runs; reaching TIMEOUT_CYCLES without core_convolution_complete -> ERROR, err=1, core_mem_load_complete=0; ERROR -> LOAD_X on start (err cleared).
REQ-021 HOST_TIMEOUT_EN undefined: no counter, ERROR unreachable, err tied 0, WAIT_CONV waits indefinitely.

Verification
REQ-022 Reset mid-LOAD_X after 10 words -> next cycle busy=0, core_cen=1, core_wen=1; new start reloads from address 0.
REQ-023 start, 144 x words then 72 w words with in_valid gapped every other cycle -> x_bank writes addr 0..143 (sel=0), w_bank writes 0..71 (sel=1), no writes on gap cycles.
REQ-024 After load, core_convolution_complete held low 50 cycles -> core_mem_load_complete high throughout; complete=1 -> core_mem_load_complete low next cycle, first read at core_addr=0.
REQ-025 Readback with out_ready stalled 5 cycles on word 3 -> out_data/out_addr=3 stable while stalled; 16 words delivered in order 0..15, done pulses once.
REQ-026 HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100, complete never asserted -> err=1, busy=0 after 100 WAIT_CONV cycles; start clears err.
